// File: rtl/mem_pkg.sv
// Shared definitions for the M (memory access) stage of the RV32I pipeline.
// Contents: datapath width, the result_src encoding that marks a load,
// funct3 width/sign encodings, the access-FSM state type, and a helper
// that flags misaligned or illegal-width memory accesses.
package mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] RS_MEM = 3'b001;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // True when funct3 is not a legal memory width, or when the byte
    // offset breaks the natural alignment of the access width.
    function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory valid/ready port.
//   req, we, addr, be, wdata : request side, driven by the stage (master)
//   ready                    : request accepted when req && ready
//   rvalid, rdata            : load response, at least one cycle after acceptance
interface memory_access_stage_if;
    import mem_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/memory_access_stage_load_store_align.sv
// Byte-lane alignment for the data-memory port (purely combinational).
//   is_store, st_funct3, st_off, st_data -> be, wdata (store lanes, replicated data)
//   ld_funct3, ld_off, rdata             -> ld_data (extracted, sign/zero-extended)
// Loads drive all four byte enables.
module load_store_align
    import mem_pkg::*;
(
    input  logic            is_store,
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        if (is_store) begin
            case (st_funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << st_off;
                    wdata = {4{st_data[7:0]}};
                end
                2'b01: begin
                    be    = 4'b0011 << st_off;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = st_data;
                end
            endcase
        end
    end

    assign lane_b = 8'(rdata >> {ld_off, 3'b000});
    assign lane_h = 16'(rdata >> {ld_off[1], 4'b0000});

    always_comb begin
        case (ld_funct3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   ld_data = {24'h0, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   ld_data = {16'h0, lane_h};
            F3_W:    ld_data = rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// M stage of the 5-stage RV32I pipeline.
// Issues loads/stores on a valid/ready data-memory port, stalls the
// upstream stages while an access is outstanding, and registers MEM/WB.
//   CLK, RST_N             : clock, async active-low reset
//   *_M inputs             : EX/MEM register outputs
//   dmem                   : data-memory master port
//   stall_M                : freeze IF..M this cycle
//   mem_fault_M            : misaligned access or illegal funct3 (combinational)
//   *_W outputs            : MEM/WB registers, read_data_W already extended
//
// state | meaning
// IDLE  | no access outstanding; a valid memory op requests combinationally
// REQ   | request presented but not yet accepted; request fields held
// WAIT  | load accepted, waiting for rvalid
module memory_access_stage
    import mem_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [2:0]      result_src_M,
    input  logic [2:0]      funct3_M,
    input  logic            reg_write_M,
    input  logic            mem_write_M,
    input  logic [XLEN-1:0] alu_result_M,
    input  logic [XLEN-1:0] alu2_mux_result_M,
    input  logic [XLEN-1:0] pc_plus4_M,
    input  logic [XLEN-1:0] ext_imm_M,
    input  logic [XLEN-1:0] pc_plus_ext_imm_M,
    input  logic [4:0]      rd_M,
    memory_access_stage_if.master dmem,
    output logic            stall_M,
    output logic            mem_fault_M,
    output logic [2:0]      result_src_W,
    output logic            reg_write_W,
    output logic [XLEN-1:0] alu_result_W,
    output logic [XLEN-1:0] read_data_W,
    output logic [XLEN-1:0] pc_plus4_W,
    output logic [XLEN-1:0] ext_imm_W,
    output logic [XLEN-1:0] pc_plus_ext_imm_W,
    output logic [4:0]      rd_W
);

    state_t          state, state_nxt;
    logic            is_store, is_load, mem_op, valid_op;
    logic            req, accept, stall, ld_done;
    logic [1:0]      off_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] ld_data;

    // A store with result_src == RS_MEM is still a store.
    assign is_store    = mem_write_M;
    assign is_load     = (result_src_M == RS_MEM) && !mem_write_M;
    assign mem_op      = is_store || is_load;
    assign mem_fault_M = mem_op && access_fault(funct3_M, alu_result_M[1:0]);
    assign valid_op    = mem_op && !mem_fault_M;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (valid_op) begin
                if (!dmem.ready)  state_nxt = ST_REQ;
                else if (is_load) state_nxt = ST_WAIT;
            end
            ST_REQ:  if (dmem.ready) state_nxt = is_load ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (dmem.rvalid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rvalid is only honoured in WAIT, so a response on the acceptance
    // cycle or while idle has no effect.
    always_comb begin
        req     = 1'b0;
        accept  = 1'b0;
        stall   = 1'b0;
        ld_done = 1'b0;
        case (state)
            ST_IDLE: begin
                req    = valid_op;
                accept = valid_op && dmem.ready;
                stall  = valid_op && !(is_store && dmem.ready);
            end
            ST_REQ: begin
                req    = 1'b1;
                accept = dmem.ready;
                stall  = !(is_store && dmem.ready);
            end
            ST_WAIT: begin
                stall   = !dmem.rvalid;
                ld_done = dmem.rvalid;
            end
            default: ;
        endcase
    end

    // Request fields come straight from the M inputs; the stall keeps
    // those inputs frozen, which holds the request stable in REQ.
    assign dmem.req  = req;
    assign dmem.we   = is_store;
    assign dmem.addr = {alu_result_M[XLEN-1:2], 2'b00};
    assign stall_M   = stall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
        end else if (accept && is_load) begin
            off_q    <= alu_result_M[1:0];
            funct3_q <= funct3_M;
        end
    end

    load_store_align u_align (
        .is_store  (is_store),
        .st_funct3 (funct3_M),
        .st_off    (alu_result_M[1:0]),
        .st_data   (alu2_mux_result_M),
        .be        (dmem.be),
        .wdata     (dmem.wdata),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .rdata     (dmem.rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_src_W      <= '0;
            reg_write_W       <= 1'b0;
            alu_result_W      <= '0;
            read_data_W       <= '0;
            pc_plus4_W        <= '0;
            ext_imm_W         <= '0;
            pc_plus_ext_imm_W <= '0;
            rd_W              <= '0;
        end else if (stall) begin
            reg_write_W <= 1'b0;
        end else begin
            result_src_W      <= result_src_M;
            reg_write_W       <= reg_write_M && !mem_fault_M;
            alu_result_W      <= alu_result_M;
            read_data_W       <= ld_done ? ld_data : '0;
            pc_plus4_W        <= pc_plus4_M;
            ext_imm_W         <= ext_imm_M;
            pc_plus_ext_imm_W <= pc_plus_ext_imm_M;
            rd_W              <= rd_M;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage.
// Inputs change 1 time unit after the rising edge; combinational outputs
// are sampled on the falling edge, W registers 1 unit after the rising edge.
module tb_memory_access_stage;
    import mem_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic [2:0]  result_src_M, funct3_M;
    logic        reg_write_M, mem_write_M;
    logic [31:0] alu_result_M, alu2_mux_result_M, pc_plus4_M, ext_imm_M, pc_plus_ext_imm_M;
    logic [4:0]  rd_M;
    logic        stall_M, mem_fault_M;
    logic [2:0]  result_src_W;
    logic        reg_write_W;
    logic [31:0] alu_result_W, read_data_W, pc_plus4_W, ext_imm_W, pc_plus_ext_imm_W;
    logic [4:0]  rd_W;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_stage_if dmem_bus ();

    memory_access_stage dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .result_src_M      (result_src_M),
        .funct3_M          (funct3_M),
        .reg_write_M       (reg_write_M),
        .mem_write_M       (mem_write_M),
        .alu_result_M      (alu_result_M),
        .alu2_mux_result_M (alu2_mux_result_M),
        .pc_plus4_M        (pc_plus4_M),
        .ext_imm_M         (ext_imm_M),
        .pc_plus_ext_imm_M (pc_plus_ext_imm_M),
        .rd_M              (rd_M),
        .dmem              (dmem_bus.master),
        .stall_M           (stall_M),
        .mem_fault_M       (mem_fault_M),
        .result_src_W      (result_src_W),
        .reg_write_W       (reg_write_W),
        .alu_result_W      (alu_result_W),
        .read_data_W       (read_data_W),
        .pc_plus4_W        (pc_plus4_W),
        .ext_imm_W         (ext_imm_W),
        .pc_plus_ext_imm_W (pc_plus_ext_imm_W),
        .rd_W              (rd_W)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input logic [2:0] rs, input logic [2:0] f3, input logic rw,
                         input logic mw, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd);
        result_src_M      = rs;
        funct3_M          = f3;
        reg_write_M       = rw;
        mem_write_M       = mw;
        alu_result_M      = addr;
        alu2_mux_result_M = rs2;
        rd_M              = rd;
        pc_plus4_M        = 32'h0000_4004;
        ext_imm_M         = 32'h0000_0010;
        pc_plus_ext_imm_M = 32'h0000_4010;
    endtask

    task automatic nop();
        set_m(3'b000, F3_B, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        set_m(3'b000, f3, 1'b0, 1'b1, addr, data, 5'd0);
        dmem_bus.ready = 1'b1;
        @(negedge CLK);
        check_eq({tag, " req"},   32'(dmem_bus.req), 32'd1);
        check_eq({tag, " we"},    32'(dmem_bus.we), 32'd1);
        check_eq({tag, " addr"},  dmem_bus.addr, {addr[31:2], 2'b00});
        check_eq({tag, " be"},    32'(dmem_bus.be), 32'(exp_be));
        check_eq({tag, " wdata"}, dmem_bus.wdata, exp_wdata);
        check_eq({tag, " stall"}, 32'(stall_M), 32'd0);
        step();
        check_eq({tag, " reg_write_W"},  32'(reg_write_W), 32'd0);
        check_eq({tag, " alu_result_W"}, alu_result_W, addr);
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input int ready_delay, input int wait_cycles,
                            input logic early_rvalid, input logic [31:0] exp);
        int n_stall = 0;
        set_m(RS_MEM, f3, 1'b1, 1'b0, addr, 32'h0, 5'd7);
        dmem_bus.ready = 1'b0;
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge CLK);
            if (stall_M) n_stall++;
            step();
        end
        dmem_bus.ready  = 1'b1;
        dmem_bus.rvalid = early_rvalid;
        dmem_bus.rdata  = 32'hFFFF_FFFF;
        @(negedge CLK);
        check_eq({tag, " req"}, 32'(dmem_bus.req), 32'd1);
        check_eq({tag, " we"},  32'(dmem_bus.we), 32'd0);
        check_eq({tag, " be"},  32'(dmem_bus.be), 32'hF);
        if (stall_M) n_stall++;
        step();
        dmem_bus.ready  = 1'b0;
        dmem_bus.rvalid = 1'b0;
        check_eq({tag, " bubble"}, 32'(reg_write_W), 32'd0);
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge CLK);
            if (stall_M) n_stall++;
            check_eq({tag, " wait req"}, 32'(dmem_bus.req), 32'd0);
            step();
        end
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = rdata;
        @(negedge CLK);
        check_eq({tag, " done stall"}, 32'(stall_M), 32'd0);
        check_eq({tag, " stall cycles"}, 32'(n_stall), 32'(ready_delay + 1 + wait_cycles));
        step();
        dmem_bus.rvalid = 1'b0;
        check_eq({tag, " read_data_W"}, read_data_W, exp);
        check_eq({tag, " reg_write_W"}, 32'(reg_write_W), 32'd1);
        check_eq({tag, " rd_W"}, 32'(rd_W), 32'd7);
        nop();
    endtask

    task automatic do_fault(input string tag, input logic [2:0] rs, input logic [2:0] f3,
                            input logic mw, input logic [31:0] addr);
        set_m(rs, f3, 1'b1, mw, addr, 32'h1234_5678, 5'd9);
        dmem_bus.ready = 1'b1;
        @(negedge CLK);
        check_eq({tag, " fault"}, 32'(mem_fault_M), 32'd1);
        check_eq({tag, " req"},   32'(dmem_bus.req), 32'd0);
        check_eq({tag, " stall"}, 32'(stall_M), 32'd0);
        step();
        check_eq({tag, " reg_write_W"},  32'(reg_write_W), 32'd0);
        check_eq({tag, " alu_result_W"}, alu_result_W, addr);
    endtask

    initial begin
        RST_N = 1'b0;
        nop();
        dmem_bus.ready  = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst reg_write_W",  32'(reg_write_W), 32'd0);
        check_eq("rst read_data_W",  read_data_W, 32'h0);
        check_eq("rst pc_plus4_W",   pc_plus4_W, 32'h0);
        check_eq("rst req",          32'(dmem_bus.req), 32'd0);
        check_eq("rst stall",        32'(stall_M), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        // Plain ALU op: one-cycle pass-through, illegal funct3 ignored for non-memory ops
        set_m(3'b000, 3'b011, 1'b1, 1'b0, 32'h1234_5677, 32'h0, 5'd5);
        pc_plus_ext_imm_M = 32'h0000_ABCD;
        dmem_bus.ready = 1'b1;
        @(negedge CLK);
        check_eq("alu req",   32'(dmem_bus.req), 32'd0);
        check_eq("alu stall", 32'(stall_M), 32'd0);
        check_eq("alu fault", 32'(mem_fault_M), 32'd0);
        step();
        check_eq("alu alu_result_W", alu_result_W, 32'h1234_5677);
        check_eq("alu reg_write_W",  32'(reg_write_W), 32'd1);
        check_eq("alu rd_W",         32'(rd_W), 32'd5);
        check_eq("alu pc_plus4_W",   pc_plus4_W, 32'h0000_4004);
        check_eq("alu ext_imm_W",    ext_imm_W, 32'h0000_0010);
        check_eq("alu pc_ext_W",     pc_plus_ext_imm_W, 32'h0000_ABCD);
        check_eq("alu read_data_W",  read_data_W, 32'h0);

        do_store("sw",  F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb3", F3_B, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store("sb1", F3_B, 32'h0000_0101, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C);
        do_store("sh2", F3_H, 32'h0000_0102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);

        run_load("lb",  F3_B,  32'h0000_0102, 32'h0080_0000, 0, 2, 1'b0, 32'hFFFF_FF80);
        run_load("lbu", F3_BU, 32'h0000_0102, 32'h0080_0000, 0, 1, 1'b1, 32'h0000_0080);
        run_load("lh",  F3_H,  32'h0000_0102, 32'h8001_0000, 1, 0, 1'b0, 32'hFFFF_8001);
        run_load("lhu", F3_HU, 32'h0000_0100, 32'h1234_8001, 0, 0, 1'b0, 32'h0000_8001);
        run_load("lw",  F3_W,  32'h0000_0104, 32'hCAFE_F00D, 2, 1, 1'b0, 32'hCAFE_F00D);
        run_load("lb0", F3_B,  32'h0000_0100, 32'h0000_007F, 0, 0, 1'b0, 32'h0000_007F);

        do_fault("lh odd",   RS_MEM, F3_H, 1'b0, 32'h0000_0101);
        do_fault("lw mis",   RS_MEM, F3_W, 1'b0, 32'h0000_0102);
        do_fault("sw mis",   3'b000, F3_W, 1'b1, 32'h0000_0102);
        do_fault("sh odd",   3'b000, F3_H, 1'b1, 32'h0000_0103);
        do_fault("ld f3 11", RS_MEM, 3'b011, 1'b0, 32'h0000_0100);

        // Store held off by ready=0 for two cycles
        set_m(3'b000, F3_W, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0, 5'd1);
        step();
        set_m(3'b000, F3_W, 1'b0, 1'b1, 32'h0000_0200, 32'h1122_3344, 5'd0);
        for (int k = 0; k < 3; k++) begin
            dmem_bus.ready = (k == 2);
            @(negedge CLK);
            check_eq("hold req",   32'(dmem_bus.req), 32'd1);
            check_eq("hold addr",  dmem_bus.addr, 32'h0000_0200);
            check_eq("hold be",    32'(dmem_bus.be), 32'hF);
            check_eq("hold wdata", dmem_bus.wdata, 32'h1122_3344);
            check_eq("hold stall", 32'(stall_M), (k < 2) ? 32'd1 : 32'd0);
            step();
            if (k < 2) begin
                check_eq("hold bubble rw",  32'(reg_write_W), 32'd0);
                check_eq("hold bubble alu", alu_result_W, 32'hAAAA_0000);
            end else begin
                check_eq("hold done alu", alu_result_W, 32'h0000_0200);
            end
        end

        // Reset while waiting for load data, then a stale rvalid
        set_m(RS_MEM, F3_W, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd3);
        dmem_bus.ready = 1'b1;
        @(negedge CLK);
        check_eq("rstw accept stall", 32'(stall_M), 32'd1);
        step();
        dmem_bus.ready = 1'b0;
        @(negedge CLK);
        check_eq("rstw wait stall", 32'(stall_M), 32'd1);
        RST_N = 1'b0;
        nop();
        #1;
        check_eq("rstw alu_result_W", alu_result_W, 32'h0);
        check_eq("rstw rd_W",         32'(rd_W), 32'd0);
        check_eq("rstw stall",        32'(stall_M), 32'd0);
        check_eq("rstw req",          32'(dmem_bus.req), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        set_m(3'b000, F3_W, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd4);
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hDEAD_BEEF;
        @(negedge CLK);
        check_eq("late rvalid stall", 32'(stall_M), 32'd0);
        step();
        dmem_bus.rvalid = 1'b0;
        check_eq("late rvalid read_data_W", read_data_W, 32'h0);
        check_eq("late rvalid alu_W",       alu_result_W, 32'h0000_0055);
        check_eq("late rvalid rw_W",        32'(reg_write_W), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
